// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: instruction width, the
// bubble encoding placed into IF/ID, the fetch FSM state type and a helper that
// word-aligns a byte address.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INSTR_W = 32;

  // Encoding written into IF/ID whenever the stage inserts a bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Instructions are word aligned, so the two low address bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: holds the fetched instruction, its PC+4 and a valid
// flag for the decode stage.
// Ports:
//   clk       in   clock, rising edge
//   rst_n_i   in   synchronous reset, active-low
//   load_i    in   capture instr_i/pc4_i and mark the entry valid
//   bubble_i  in   overwrite with a NOP bubble (wins over load_i)
//   instr_i   in   instruction word to capture
//   pc4_i     in   PC+4 of that instruction
//   instr_o   out  registered instruction (NOP when bubble)
//   pc4_o     out  registered PC+4 (0 when bubble)
//   valid_o   out  1 = instr_o is a real fetched instruction
// With neither load_i nor bubble_i the register holds (stall).
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc4_q;
  logic               valid_q;

  // NOTE: reset is synchronous (sampled only on the rising edge), so it lives
  // inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the 5-stage pipeline. Owns the PC, presents it combinationally
// to the instruction memory and captures the returned word into IF/ID.
// Handles stall, branch/jump redirect with wrong-path squash, and halts when
// the PC leaves the instruction memory.
// Parameters:
//   RESET_PC   PC loaded on reset
//   MEM_BYTES  instruction memory size in bytes; legal fetch iff pc <= MEM_BYTES-4
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-low
//   stall         in   hold PC and IF/ID this cycle
//   redirect      in   taken branch/jump from EX this cycle
//   redirect_pc   in   redirect target (low two bits ignored)
//   imem_pc       out  byte address to instruction memory (= pc_q)
//   imem_instr    in   word returned for imem_pc, same cycle
//   if_id_instr   out  registered instruction (NOP on bubble)
//   if_id_pc4     out  registered PC+4 of that instruction
//   if_id_valid   out  1 = if_id_instr is a real instruction
//   fetch_halted  out  1 = FSM in HALT
// Edge priority: reset > redirect > HALT hold > stall > normal advance.
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               fetch_halted
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  logic [31:0]  pc_q, pc_d;
  fetch_state_t state_q, state_d;
  logic         load, bubble;
  logic [31:0]  pc_plus4;
  logic         pc_legal;

  assign pc_plus4 = pc_q + 32'd4;
  // Unsigned compare; 32'hFFFF_FFFC is caught here before PC+4 could wrap.
  assign pc_legal = (pc_q <= LAST_PC);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    load    = 1'b0;
    bubble  = 1'b0;
    if (redirect) begin
      // Squash the wrong-path fetch; a concurrent stall is dropped.
      pc_d    = align_word(redirect_pc);
      state_d = RUN;
      bubble  = 1'b1;
    end else if (state_q == HALT) begin
      bubble  = 1'b1;
    end else if (stall) begin
      // Hold everything; an illegal PC is only acted on once stall drops.
    end else if (pc_legal) begin
      pc_d    = pc_plus4;
      load    = 1'b1;
    end else begin
      // imem_instr is not captured for an out-of-range address.
      state_d = HALT;
      bubble  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n_i  (rst),
    .load_i   (load),
    .bubble_i (bubble),
    .instr_i  (imem_instr),
    .pc4_i    (pc_plus4),
    .instr_o  (if_id_instr),
    .pc4_o    (if_id_pc4),
    .valid_o  (if_id_valid)
  );

  assign imem_pc      = pc_q;
  assign fetch_halted = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed stimulus for fetch_stage with MEM_BYTES=32. Each step drives one
// cycle of inputs and queues the hand-computed post-edge outputs; a separate
// monitor pops and compares on every falling edge.
// Memory image (big-endian): 0x20010005 @0, 0x20020006 @4, 0x00221820 @8..28;
// addresses outside the array return X.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_halted;

  logic [7:0]  mem [0:31];
  exp_t        exp_q [$];
  int          checks;
  int          errors;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_pc      (imem_pc),
    .imem_instr   (imem_instr),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .fetch_halted (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian instruction memory.
  always_comb begin
    imem_instr = 'x;
    if (imem_pc < 32'd32) begin
      imem_instr = {mem[imem_pc[4:0]], mem[imem_pc[4:0] + 5'd1],
                    mem[imem_pc[4:0] + 5'd2], mem[imem_pc[4:0] + 5'd3]};
    end
  end

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  // One clock of stimulus; the expectation describes outputs after the edge.
  task automatic step(input string name, input logic r, input logic s,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic e_valid, input logic e_halt,
                      input logic [31:0] e_pc);
    exp_t e;
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    e.name   = name;
    e.instr  = e_instr;
    e.pc4    = e_pc4;
    e.valid  = e_valid;
    e.halted = e_halt;
    e.pc     = e_pc;
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: outputs are registered, so they are sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (if_id_instr !== e.instr || if_id_pc4 !== e.pc4 ||
          if_id_valid !== e.valid || fetch_halted !== e.halted ||
          imem_pc !== e.pc) begin
        errors++;
        $display("FAIL %s: got instr=%h pc4=%h valid=%b halted=%b pc=%h, want instr=%h pc4=%h valid=%b halted=%b pc=%h",
                 e.name, if_id_instr, if_id_pc4, if_id_valid, fetch_halted, imem_pc,
                 e.instr, e.pc4, e.valid, e.halted, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    put_word(0, 32'h2001_0005);
    put_word(4, 32'h2002_0006);
    for (int a = 8; a <= 28; a += 4) put_word(a, 32'h0022_1820);

    //    name            rst  stl  rd   rpc            instr          pc4    v   h   pc
    step("reset0",        0,   0,   0,   32'h0,         32'h0,         32'h0,  0,  0,  32'h0);
    step("reset1",        0,   0,   0,   32'h0,         32'h0,         32'h0,  0,  0,  32'h0);
    step("fetch0",        1,   0,   0,   32'h0,         32'h2001_0005, 32'd4,  1,  0,  32'd4);
    step("fetch4",        1,   0,   0,   32'h0,         32'h2002_0006, 32'd8,  1,  0,  32'd8);
    for (int i = 0; i < 3; i++)
      step("stall_hold",  1,   1,   0,   32'h0,         32'h2002_0006, 32'd8,  1,  0,  32'd8);
    step("resume8",       1,   0,   0,   32'h0,         32'h0022_1820, 32'd12, 1,  0,  32'd12);
    step("redir_stall",   1,   1,   1,   32'h7,         32'h0,         32'h0,  0,  0,  32'd4);
    step("after_redir",   1,   0,   0,   32'h0,         32'h2002_0006, 32'd8,  1,  0,  32'd8);
    for (int p = 8; p <= 28; p += 4)
      step("seq_run",     1,   0,   0,   32'h0,         32'h0022_1820, 32'(p + 4), 1, 0, 32'(p + 4));
    step("halt_enter",    1,   0,   0,   32'h0,         32'h0,         32'h0,  0,  1,  32'd32);
    step("halt_stall",    1,   1,   0,   32'h0,         32'h0,         32'h0,  0,  1,  32'd32);
    step("halt_redir0",   1,   0,   1,   32'h0,         32'h0,         32'h0,  0,  0,  32'h0);
    step("resume0",       1,   0,   0,   32'h0,         32'h2001_0005, 32'd4,  1,  0,  32'd4);
    step("stall_a",       1,   1,   0,   32'h0,         32'h2001_0005, 32'd4,  1,  0,  32'd4);
    step("rst_in_stall",  0,   1,   0,   32'h0,         32'h0,         32'h0,  0,  0,  32'h0);
    step("post_rst",      1,   0,   0,   32'h0,         32'h2001_0005, 32'd4,  1,  0,  32'd4);
    step("redir_illegal", 1,   0,   1,   32'h40,        32'h0,         32'h0,  0,  0,  32'h40);
    step("illegal_stall", 1,   1,   0,   32'h0,         32'h0,         32'h0,  0,  0,  32'h40);
    step("illegal_halt",  1,   0,   0,   32'h0,         32'h0,         32'h0,  0,  1,  32'h40);
    step("rst_in_halt",   0,   0,   0,   32'h0,         32'h0,         32'h0,  0,  0,  32'h0);
    step("rst_vs_redir",  0,   0,   1,   32'h8,         32'h0,         32'h0,  0,  0,  32'h0);
    step("redir_last",    1,   0,   1,   32'h1F,        32'h0,         32'h0,  0,  0,  32'd28);
    step("fetch_last",    1,   0,   0,   32'h0,         32'h0022_1820, 32'd32, 1,  0,  32'd32);
    step("halt_after28",  1,   0,   0,   32'h0,         32'h0,         32'h0,  0,  1,  32'd32);
    step("redir_top",     1,   0,   1,   32'hFFFF_FFFE, 32'h0,         32'h0,  0,  0,  32'hFFFF_FFFC);
    step("halt_top",      1,   0,   0,   32'h0,         32'h0,         32'h0,  0,  1,  32'hFFFF_FFFC);
    step("halt_top_hold", 1,   0,   0,   32'h0,         32'h0,         32'h0,  0,  1,  32'hFFFF_FFFC);

    // Let the monitor drain the remaining expectations, with a cycle bound.
    for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
